// File: rtl/bus_init.sv
// Single-outstanding ECO32 peripheral bus initiator: command in, one bus cycle out, response back.
// Optional wait-state timeout compiled in with `define BUS_INIT_TIMEOUT_EN.
module bus_init #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              bus_en,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_dout,
  input  logic [31:0]       bus_din,
  input  logic              bus_wt
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // BUS   | bus cycle in flight, stretched by bus_wt
  // RSP   | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        timed_out;

`ifdef BUS_INIT_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  assign timed_out = bus_wt && (wait_cnt == WAIT_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_en    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= BUS;
            cmd_ready <= 1'b0;
            bus_en    <= 1'b1;
            bus_wr    <= cmd_wr;
            bus_addr  <= cmd_addr;
            bus_dout  <= cmd_wr ? cmd_wdata : 32'd0;
            wait_cnt  <= '0;
          end
        end
        BUS: begin
          if (!bus_wt || timed_out) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            // Completion takes priority: timed_out is only true while bus_wt is high.
            rsp_rdata <= (!bus_wt && !bus_wr) ? bus_din : 32'd0;
            rsp_err   <= timed_out;
            bus_en    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_dout  <= '0;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          bus_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_init.md
# bus_init

Single-outstanding bus initiator for the ECO32 peripheral bus. Accepts read/write commands on a valid/ready upstream port, drives one bus transaction (`en`/`wr`/`addr`/data, stretched by `wt`) to a responder such as the timer, and returns read data or a write acknowledge on a valid/ready response port. Used by debug/boot sequencers and test harnesses that need to reach peripherals without the CPU.

## Interface

Parameters:
- `ADDR_W`, default 16: bus address width.
- `TIMEOUT`, default 255: wait-state limit, in cycles. Legal range is 1..65535. Only used when the timeout is compiled in.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: initiator accepts a command.
- `cmd_wr`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, ADDR_W: target address.
- `cmd_wdata`, in, 32: write data.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_rdata`, out, 32: read data. 0 for writes and errors.
- `rsp_err`, out, 1: transaction timed out.
- `bus_en`, out, 1: bus cycle active.
- `bus_wr`, out, 1: bus write strobe.
- `bus_addr`, out, ADDR_W: bus address.
- `bus_dout`, out, 32: write data to the responder.
- `bus_din`, in, 32: read data from the responder. Valid when `bus_en & ~bus_wt`.
- `bus_wt`, in, 1: responder wait request.

## Operation

- FSM states:
  - `IDLE`: `cmd_ready=1`. On `cmd_valid`, latch `wr`/`addr`/`wdata`, clear the wait counter, go to `BUS`.
  - `BUS`: `bus_en=1`, `bus_wr=latched wr`, `bus_addr=latched addr`. `bus_dout` carries latched wdata on writes and 0 on reads.
    - The transaction completes in the first `BUS` cycle with `bus_wt=0`.
    - On completion, capture `bus_din` into `rsp_rdata` (reads; 0 for writes), set `rsp_err=0`, go to `RSP`.
    - While `bus_wt=1`, increment the wait counter.
  - `RSP`: `rsp_valid=1`, outputs held stable. On `rsp_ready`, go to `IDLE`.
- Bus signal discipline:
  - `wr`, `addr` and `dout` do not change while `bus_en=1`.
  - Outside `BUS`: `bus_en=0`, `bus_wr=0`, `bus_addr=0`, `bus_dout=0`.
- Single outstanding transaction. `cmd_ready=0` in `BUS` and `RSP`; `cmd_valid` in those states is ignored and not latched.
- All outputs are registered.
- `bus_din` is sampled only on the completing cycle. Its value while `bus_wt=1` is ignored.
- Wait counter is 16 bits and saturates at 65535. It never wraps.

## Timing

- Reset values:
  - `cmd_ready=1` (state `IDLE`).
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `bus_en=0`, `bus_wr=0`, `bus_addr=0`, `bus_dout=0`.
- Command accepted at edge N: `bus_en=1` during cycle N+1.
- Zero-wait responder (`bus_wt=0` in cycle N+1): `bus_en=0` and `rsp_valid=1` in cycle N+2. Latency is 2 cycles.
- Responder with k wait cycles: `rsp_valid=1` in cycle N+2+k.
- `bus_en` stays high for exactly k+1 cycles per transaction.
- Response accepted at edge M (`rsp_valid & rsp_ready`): `cmd_ready=1` in cycle M+1. Back-to-back commands therefore start every 3 cycles with zero wait.
- Reset mid-operation: reset sampled at edge R forces all outputs to their reset values in cycle R+1, including `bus_en=0` even mid-`BUS`. The pending command and response are discarded.
- `rsp_ready` asserted outside `RSP` has no effect.

## Configuration

- `BUS_INIT_TIMEOUT_EN` defined:
  - In `BUS`, if `bus_wt=1` and the wait counter equals `TIMEOUT-1`, abort at that edge.
  - Next cycle: `bus_en=0`, state `RSP`, `rsp_err=1`, `rsp_rdata=0`. A write is reported as failed.
  - Net effect: `bus_en` stays high for exactly `TIMEOUT` cycles, then the response shows the error.
  - Completion and timeout on the same edge (`bus_wt=0`): completion wins and `rsp_err=0`.
- `BUS_INIT_TIMEOUT_EN` undefined:
  - No timeout; the initiator waits indefinitely on `bus_wt`.
  - `rsp_err` is constant 0.
  - `TIMEOUT` is unused.

## Test plan

- Write to a zero-wait responder: `cmd_wr=1`, `addr=1`, `wdata=0x0000C350`.
  - `bus_en=1` for 1 cycle with those values.
  - Then `rsp_valid=1`, `rsp_rdata=0`, `rsp_err=0` two cycles after acceptance.
- Read with 3 wait cycles, responder returning `0x00000003`.
  - `bus_en` high for 4 cycles; address and data stable throughout.
  - `rsp_rdata=0x00000003`, `rsp_valid` at acceptance+5.
  - Garbage on `bus_din` during the wait cycles must not appear in the response.
- Timeout (macro defined, `TIMEOUT=4`, `bus_wt` stuck at 1).
  - `bus_en` high for exactly 4 cycles.
  - Then `rsp_err=1`, `rsp_rdata=0`.
  - Repeat with `bus_wt` dropping in the 4th cycle: expect `rsp_err=0`.
- Response backpressure: `rsp_ready=0` for 10 cycles after a read.
  - `rsp_valid` and `rsp_rdata` stay stable; `cmd_ready=0`; a second `cmd_valid` is not accepted.
  - After `rsp_ready=1`, `cmd_ready=1` next cycle.
- Reset asserted in the second `BUS` cycle of a waited read.
  - Next cycle: `bus_en=0`, `rsp_valid=0`, `cmd_ready=1`.
  - No response is ever produced for that command.
